// File: rtl/bf_loop_stack_ctrl.sv
// bf_loop_stack_ctrl: multi-cycle Brainfuck sequencer with a loop-return stack and bracket-skip scanning.
module bf_loop_stack_ctrl #(
    parameter int PC_W        = 8,
    parameter int DP_W        = 8,
    parameter int DW          = 8,
    parameter int STACK_DEPTH = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic [PC_W-1:0] prog_addr,
    input  logic [3:0]      prog_op,
    output logic [DP_W-1:0] data_addr,
    input  logic [DW-1:0]   data_rd,
    output logic [DW-1:0]   data_wr,
    output logic            data_we,
    input  logic            in_valid,
    input  logic [DW-1:0]   in_data,
    output logic            in_ready,
    output logic            out_valid,
    output logic [DW-1:0]   out_data,
    input  logic            out_ready,
    output logic            busy,
    output logic            halted,
    output logic [1:0]      err_code
);
    localparam int SP_W = $clog2(STACK_DEPTH + 1);
    localparam int IX_W = $clog2(STACK_DEPTH);
    typedef enum logic [3:0] {IDLE, FETCH, DECODE, EXEC, OUT_WAIT, IN_WAIT, SKIP_FETCH, SKIP_CHK, HALT, ERR} state_t;
    state_t state, state_nx;
    logic [PC_W-1:0] pc, pc_nx, depth, depth_nx, skip_d, pc_inc;
    logic [DP_W-1:0] dp, dp_nx;
    logic [SP_W-1:0] sp, sp_nx;
    logic [IX_W-1:0] sp_ix, top_ix;
    logic [3:0]      op, op_nx;
    logic [DW-1:0]   out_q, out_nx;
    logic [1:0]      err, err_nx;
    logic            push, cell_nz;
    logic [PC_W-1:0] stack [STACK_DEPTH];
    assign pc_inc    = pc + PC_W'(1);
    assign sp_ix     = sp[IX_W-1:0];
    assign top_ix    = IX_W'(sp - SP_W'(1));
    assign cell_nz   = data_rd != '0;
    assign skip_d    = prog_op == 4'd4 ? depth + PC_W'(1) : prog_op == 4'd5 ? depth - PC_W'(1) : depth;
    assign prog_addr = pc;
    assign data_addr = dp;
    assign out_data  = out_q;
    assign err_code  = err;
    assign busy      = !(state inside {IDLE, HALT, ERR});
    assign halted    = state == HALT;
    assign out_valid = state == OUT_WAIT;
    assign in_ready  = state == IN_WAIT;
    assign data_we   = (state == EXEC && (op == 4'd2 || op == 4'd3)) || (state == IN_WAIT && in_valid);
    assign data_wr   = state == IN_WAIT ? in_data :
                       state == EXEC && op == 4'd2 ? data_rd + DW'(1) :
                       state == EXEC && op == 4'd3 ? data_rd - DW'(1) : '0;
    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        dp_nx    = dp;
        sp_nx    = sp;
        depth_nx = depth;
        op_nx    = op;
        out_nx   = out_q;
        err_nx   = err;
        push     = 1'b0;
        case (state)
            IDLE, HALT, ERR: if (start) begin
                state_nx = FETCH;
                pc_nx    = '0;
                dp_nx    = '0;
                sp_nx    = '0;
                depth_nx = '0;
                err_nx   = 2'd0;
            end
            FETCH: state_nx = DECODE;
            DECODE: begin
                op_nx = prog_op;
                case (prog_op)
                    4'd0, 4'd1: begin
                        dp_nx    = prog_op[0] ? dp + DP_W'(1) : dp - DP_W'(1);
                        pc_nx    = pc_inc;
                        state_nx = FETCH;
                    end
                    4'd2, 4'd3, 4'd4, 4'd5, 4'd6: state_nx = EXEC;
                    4'd7:  state_nx = IN_WAIT;
                    4'd15: state_nx = HALT;
                    default: begin
                        state_nx = ERR;
                        err_nx   = 2'd1;
                    end
                endcase
            end
            EXEC: begin
                case (op)
                    4'd2, 4'd3: begin
                        pc_nx    = pc_inc;
                        state_nx = FETCH;
                    end
                    4'd4: begin
                        // A zero cell jumps into forward scanning; the stack is only touched when entering the loop body.
                        state_nx = !cell_nz ? SKIP_FETCH : sp == SP_W'(STACK_DEPTH) ? ERR : FETCH;
                        err_nx   = cell_nz && sp == SP_W'(STACK_DEPTH) ? 2'd2 : err;
                        push     = cell_nz && sp != SP_W'(STACK_DEPTH);
                        sp_nx    = push ? sp + SP_W'(1) : sp;
                        pc_nx    = state_nx == ERR ? pc : pc_inc;
                        depth_nx = cell_nz ? depth : PC_W'(1);
                    end
                    4'd5: begin
                        state_nx = sp == '0 ? ERR : FETCH;
                        err_nx   = sp == '0 ? 2'd3 : err;
                        pc_nx    = sp == '0 ? pc : cell_nz ? stack[top_ix] : pc_inc;
                        sp_nx    = sp != '0 && !cell_nz ? sp - SP_W'(1) : sp;
                    end
                    default: begin
                        out_nx   = data_rd;
                        state_nx = OUT_WAIT;
                    end
                endcase
            end
            OUT_WAIT: if (out_ready) begin
                pc_nx    = pc_inc;
                state_nx = FETCH;
            end
            IN_WAIT: if (in_valid) begin
                pc_nx    = pc_inc;
                state_nx = FETCH;
            end
            SKIP_FETCH: state_nx = SKIP_CHK;
            SKIP_CHK: begin
                if (prog_op == 4'd15 || (skip_d != '0 && pc == '1)) begin
                    state_nx = ERR;
                    err_nx   = 2'd3;
                end else begin
                    state_nx = skip_d == '0 ? FETCH : SKIP_FETCH;
                    depth_nx = skip_d;
                    pc_nx    = pc_inc;
                end
            end
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            pc    <= '0;
            dp    <= '0;
            sp    <= '0;
            depth <= '0;
            op    <= '0;
            out_q <= '0;
            err   <= '0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            dp    <= dp_nx;
            sp    <= sp_nx;
            depth <= depth_nx;
            op    <= op_nx;
            out_q <= out_nx;
            err   <= err_nx;
        end
    end
    always_ff @(posedge clk) if (push) stack[sp_ix] <= pc_inc;
endmodule
